// File: rtl/group_rr_arbiter_if.sv
// Handshake bundle between the group round-robin arbiter and its requesters/consumer.
// Carries the optional per-requester lock vector when LOCK_EN is defined.
interface group_rr_arbiter_if #(
  parameter int unsigned GW = 10,
  parameter int unsigned NG = 4
);
  localparam int unsigned AW = $clog2(NG);

  logic [NG*GW-1:0] x;
  logic [NG-1:0]    req;
  logic [NG-1:0]    gnt;
  logic [AW-1:0]    a;
  logic [GW-1:0]    y;
  logic             vld;
  logic             rdy;
`ifdef LOCK_EN
  logic [NG-1:0]    lock;
`endif

  modport master (
    input  x, req, rdy,
`ifdef LOCK_EN
    input  lock,
`endif
    output gnt, a, y, vld
  );

  modport slave (
    output x, req, rdy,
`ifdef LOCK_EN
    output lock,
`endif
    input  gnt, a, y, vld
  );
endinterface

// File: rtl/group_rr_arbiter.sv
// Round-robin arbiter over NG groups of a shared bus; captures the winning group and holds it
// on a VLD/RDY handshake. Define LOCK_EN to let a locked requester burst without losing the grant.
module group_rr_arbiter #(
  parameter int unsigned GW = 10,
  parameter int unsigned NG = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  group_rr_arbiter_if.master  io_bus
);
  localparam int unsigned AW = $clog2(NG);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_a, w_a_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic [GW-1:0] r_y, w_y_nxt;
  logic [NG-1:0] w_a_oh;
  logic [NG-1:0] w_elig;
  logic [NG-1:0] w_gnt;
  logic [AW-1:0] w_win;
  logic          w_found;
  logic          w_lock_hold;

  always_comb begin
    w_a_oh      = {{(NG-1){1'b0}}, 1'b1} << r_a;
    w_lock_hold = 1'b0;
`ifdef LOCK_EN
    w_lock_hold = io_bus.lock[r_a] & io_bus.req[r_a];
`endif
    // The requester being granted this cycle may not win the same edge (unless locked).
    w_elig  = (r_state == StHold) ? (io_bus.req & ~w_a_oh) : io_bus.req;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= int'(NG); k++) begin
      if (!w_found && w_elig[(int'(r_ptr) + k) % int'(NG)]) begin
        w_found = 1'b1;
        w_win   = AW'((int'(r_ptr) + k) % int'(NG));
      end
    end
    if (r_state == StHold && w_lock_hold) begin
      w_found = 1'b1;
      w_win   = r_a;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_y_nxt     = r_y;
    w_ptr_nxt   = r_ptr;
    w_gnt       = '0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_nxt = StHold;
          w_a_nxt     = w_win;
          w_y_nxt     = io_bus.x[int'(w_win)*GW +: GW];
        end
      end
      StHold: begin
        if (io_bus.rdy) begin
          w_gnt     = w_a_oh;
          w_ptr_nxt = w_lock_hold ? r_ptr : r_a;
          if (w_found) begin
            w_a_nxt = w_win;
            w_y_nxt = io_bus.x[int'(w_win)*GW +: GW];
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_y     <= '0;
      r_ptr   <= AW'(NG - 1);
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_y     <= w_y_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign io_bus.gnt = i_rst ? '0 : w_gnt;
  assign io_bus.a   = r_a;
  assign io_bus.y   = r_y;
  assign io_bus.vld = (r_state == StHold);
endmodule

// File: tb/tb_group_rr_arbiter.sv
// Directed, table-driven bench for group_rr_arbiter (GW=10, NG=4); lock burst checked under LOCK_EN.
module tb_group_rr_arbiter;
  localparam logic [9:0]  G0  = 10'h011;
  localparam logic [9:0]  G1  = 10'h122;
  localparam logic [9:0]  G2  = 10'h2AB;
  localparam logic [9:0]  G3  = 10'h3C4;
  localparam logic [39:0] X_A = {G3, G2, G1, G0};
  localparam logic [39:0] X_B = ~X_A;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  group_rr_arbiter_if #(.GW(10), .NG(4)) bus ();

  group_rr_arbiter #(.GW(10), .NG(4)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       xalt;
    logic       vld;
    logic [1:0] a;
    logic [9:0] y;
    logic [3:0] gnt;
    logic       chk_ay;
  } vec_t;

  vec_t vecs [0:30];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic rd, input logic [39:0] xv,
                       input logic [3:0] lk);
    @(posedge clk);
    #1;
    rst     = r;
    bus.req = rq;
    bus.rdy = rd;
    bus.x   = xv;
`ifdef LOCK_EN
    bus.lock = lk;
`else
    if (lk != 4'b0) $display("note: lock ignored in this build");
`endif
  endtask

  task automatic expect_out(input string nm, input logic vld, input logic [1:0] a,
                            input logic [9:0] y, input logic [3:0] gnt, input logic chk_ay);
    @(negedge clk);
    check({nm, ".vld"}, 32'(bus.vld), 32'(vld));
    check({nm, ".gnt"}, 32'(bus.gnt), 32'(gnt));
    if (chk_ay) begin
      check({nm, ".a"}, 32'(bus.a), 32'(a));
      check({nm, ".y"}, 32'(bus.y), 32'(y));
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.req  = 4'hF;
    bus.rdy  = 1'b1;
    bus.x    = X_A;
`ifdef LOCK_EN
    bus.lock = 4'b0;
`endif

    //            rst  req   rdy  xalt vld a  y    gnt   chk
    vecs[0]  = '{1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 4'h0, 1'b1};
    vecs[1]  = '{1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 4'h0, 1'b1};
    vecs[2]  = '{1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 4'h0, 1'b1};
    vecs[3]  = '{1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd0, G0,    4'h1, 1'b1};
    vecs[4]  = '{1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd1, G1,    4'h2, 1'b1};
    vecs[5]  = '{1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd2, G2,    4'h4, 1'b1};
    vecs[6]  = '{1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd3, G3,    4'h8, 1'b1};
    vecs[7]  = '{1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd0, G0,    4'h1, 1'b1};
    // Stall on A=1 with X toggling underneath.
    vecs[8]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, G1,    4'h0, 1'b1};
    vecs[9]  = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, G1,    4'h0, 1'b1};
    vecs[10] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, G1,    4'h0, 1'b1};
    vecs[11] = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, G1,    4'h0, 1'b1};
    vecs[12] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, G1,    4'h0, 1'b1};
    vecs[13] = '{1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd1, G1,    4'h2, 1'b1};
    vecs[14] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd2, G2,    4'h4, 1'b1};
    vecs[15] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 4'h0, 1'b0};
    // Single request for group 2.
    vecs[16] = '{1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 4'h0, 1'b0};
    vecs[17] = '{1'b0, 4'h4, 1'b1, 1'b0, 1'b1, 2'd2, G2,    4'h4, 1'b1};
    vecs[18] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 4'h0, 1'b0};
    // Sole requester sees a bubble between grants.
    vecs[19] = '{1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 4'h0, 1'b0};
    vecs[20] = '{1'b0, 4'h2, 1'b1, 1'b0, 1'b1, 2'd1, G1,    4'h2, 1'b1};
    vecs[21] = '{1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 4'h0, 1'b0};
    vecs[22] = '{1'b0, 4'h2, 1'b1, 1'b0, 1'b1, 2'd1, G1,    4'h2, 1'b1};
    vecs[23] = '{1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 4'h0, 1'b0};
    vecs[24] = '{1'b0, 4'h8, 1'b1, 1'b0, 1'b1, 2'd1, G1,    4'h2, 1'b1};
    // Reset while holding A=3 drops the beat.
    vecs[25] = '{1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 2'd3, G3,    4'h0, 1'b1};
    vecs[26] = '{1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 2'd3, G3,    4'h0, 1'b1};
    vecs[27] = '{1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 4'h0, 1'b1};
    vecs[28] = '{1'b0, 4'h8, 1'b1, 1'b0, 1'b1, 2'd0, G0,    4'h1, 1'b1};
    vecs[29] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd3, G3,    4'h8, 1'b1};
    vecs[30] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 4'h0, 1'b0};

    for (int i = 0; i <= 30; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].rdy, vecs[i].xalt ? X_B : X_A, 4'h0);
      expect_out($sformatf("v%0d", i), vecs[i].vld, vecs[i].a, vecs[i].y, vecs[i].gnt,
                 vecs[i].chk_ay);
    end

    // Request withdrawn while its beat is held: beat still delivered with captured data.
    drive(1'b0, 4'h4, 1'b0, X_A, 4'h0);
    expect_out("nr0", 1'b0, 2'd0, 10'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, X_B, 4'h0);
    expect_out("nr1", 1'b1, 2'd2, G2, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, X_B, 4'h0);
    expect_out("nr2", 1'b1, 2'd2, G2, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b1, X_B, 4'h0);
    expect_out("nr3", 1'b1, 2'd2, G2, 4'h4, 1'b1);
    drive(1'b0, 4'h0, 1'b1, X_A, 4'h0);
    expect_out("nr4", 1'b0, 2'd0, 10'h0, 4'h0, 1'b0);

`ifdef LOCK_EN
    // Locked requester 0 bursts; ptr stays at 2 so requester 1 follows once the lock drops.
    drive(1'b0, 4'h3, 1'b1, X_A, 4'h1);
    expect_out("lk0", 1'b0, 2'd0, 10'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h3, 1'b1, X_A, 4'h1);
    expect_out("lk1", 1'b1, 2'd0, G0, 4'h1, 1'b1);
    drive(1'b0, 4'h3, 1'b1, X_A, 4'h1);
    expect_out("lk2", 1'b1, 2'd0, G0, 4'h1, 1'b1);
    drive(1'b0, 4'h3, 1'b1, X_A, 4'h0);
    expect_out("lk3", 1'b1, 2'd0, G0, 4'h1, 1'b1);
    drive(1'b0, 4'h2, 1'b1, X_A, 4'h0);
    expect_out("lk4", 1'b1, 2'd1, G1, 4'h2, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
